// File: rtl/dmx_dispatch_seq.sv
// Serial-to-demux dispatch sequencer: spreads a valid/ready bit stream over the enabled
// 1:4 demux channels, with a guard cycle per select change. Optional macro: DMX_UNDERRUN_EN.
//
// state   | meaning
// IDLE    | waiting for start with a non-empty channel mask
// SELECT  | guard cycle: move select, force data low, load bit counter
// DRIVE   | accept dwell bits on the current channel
// ADVANCE | force data low, step to next enabled channel or finish frame
module dmx_dispatch_seq #(
    parameter int DWELL_W = 4,
    parameter int NCH     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               data_ready,
    output logic               dmx_in,
    output logic [1:0]         dmx_sel,
    output logic               busy,
    output logic               frame_done
`ifdef DMX_UNDERRUN_EN
    ,
    output logic               underrun
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SELECT  = 2'd1;
    localparam logic [1:0] S_DRIVE   = 2'd2;
    localparam logic [1:0] S_ADVANCE = 2'd3;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    logic [1:0]         state;
    logic [3:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic [1:0]         ptr;
    logic [1:0]         first_ch;
    logic [1:0]         next_ch;
    logic               has_next;
    logic               start_ok;

    assign start_ok   = (state == S_IDLE) && start && (chan_mask != 4'b0000);
    assign data_ready = (state == S_DRIVE);

    // Descending scans so the last hit is the lowest qualifying channel.
    always_comb begin
        first_ch = 2'd0;
        next_ch  = ptr;
        has_next = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_ch = 2'(i);
            end
            if (mask_q[i] && (i > int'(ptr))) begin
                next_ch  = 2'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mask_q     <= 4'b0000;
            dwell_q    <= '0;
            cnt        <= '0;
            ptr        <= 2'd0;
            dmx_in     <= 1'b0;
            dmx_sel    <= 2'b00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        mask_q  <= chan_mask;
                        dwell_q <= (dwell == '0) ? DWELL_ONE : dwell;
                        ptr     <= first_ch;
                        busy    <= 1'b1;
                        state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    dmx_sel <= ptr;
                    dmx_in  <= 1'b0;
                    cnt     <= dwell_q;
                    state   <= S_DRIVE;
                end
                S_DRIVE: begin
                    if (data_valid) begin
                        dmx_in <= data_in;
                        cnt    <= cnt - DWELL_ONE;
                        if (cnt == DWELL_ONE) begin
                            state <= S_ADVANCE;
                        end
                    end
                end
                S_ADVANCE: begin
                    dmx_in <= 1'b0;
                    if (has_next) begin
                        ptr   <= next_ch;
                        state <= S_SELECT;
                    end else begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMX_UNDERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (start_ok) begin
            underrun <= 1'b0;
        end else if ((state == S_DRIVE) && !data_valid) begin
            underrun <= 1'b1;
        end
    end
`endif

endmodule
